// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared types and constants for the shift sequencer: FSM state
//               encoding, operation codes and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    // Default operand width and the matching shift-amount width (clog2).
    localparam int DATA_W_DEFAULT  = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    // Operation codes carried on the op input.
    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-bit shift of a word. Shifts left with a
//               zero fill, or (when SRA_EN is set) right with the sign bit
//               replicated into the MSB. With SRA_EN clear only the left
//               shifter exists and shift_right is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step #(
    parameter int DATA_W = 32,
    parameter bit SRA_EN = 1'b0
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              shift_right,
    output logic [DATA_W-1:0] data_out
);

    generate
        if (SRA_EN) begin : g_bidir
            // Arithmetic right keeps the sign bit; left drops the MSB.
            assign data_out = shift_right ? {data_in[DATA_W-1], data_in[DATA_W-1:1]}
                                          : {data_in[DATA_W-2:0], 1'b0};
        end else begin : g_sll_only
            // Left-only build: direction input and the outgoing MSB are unused.
            logic [1:0] unused_bits;
            assign unused_bits = {shift_right, data_in[DATA_W-1]};
            assign data_out    = {data_in[DATA_W-2:0], 1'b0};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle barrel-free shifter. A request captures operand,
//               shift amount and operation, then the work register moves one
//               bit per clock until the count expires; result is loaded on
//               the edge entering DONE and done pulses for one cycle.
//               Build option SHIFT_SEQ_SRA_EN: when defined, op selects SLL
//               or SRA; when undefined, every operation is SLL and no
//               right-shift logic is built.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT   // must equal clog2(DATA_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   work;
    logic [DATA_W-1:0]   work_step;
    logic [SHAMT_W-1:0]  count;
    logic                accept;
    logic                step_right;

    // A request is only honoured when no operation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef SHIFT_SEQ_SRA_EN
    localparam bit SRA_BUILD = 1'b1;
    logic op_q;

    // Capture the operation with the operands; it steers every step.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q <= OP_SLL;
        end else if (accept) begin
            op_q <= op;
        end
    end

    assign step_right = (op_q == OP_SRA);
`else
    localparam bit SRA_BUILD = 1'b0;
    logic unused_op;

    assign unused_op  = op;
    assign step_right = OP_SLL;
`endif

    shift_step #(
        .DATA_W (DATA_W),
        .SRA_EN (SRA_BUILD)
    ) u_shift_step (
        .data_in     (work),
        .shift_right (step_right),
        .data_out    (work_step)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: SHIFT leaves once the count is 0 or on its final step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count <= SHAMT_W'(1)) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, step while shifting, publish on exit.
    always_ff @(posedge clock) begin
        if (reset) begin
            work   <= '0;
            count  <= '0;
            result <= '0;
        end else if (accept) begin
            work  <= data_in;
            count <= shamt;
        end else if (state == SHIFT) begin
            if (count == '0) begin
                result <= work;
            end else begin
                work  <= work_step;
                count <= count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    result <= work_step;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer. Directed cases plus
//               randomized operations compared against an arithmetic model
//               of the shift (<< and >>> on the whole word) and of the
//               done timing (max(shamt,1) edges after the accepting edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_SRA_EN
    localparam bit SRA_EN = 1'b1;
`else
    localparam bit SRA_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks;
    int          errors;
    logic [31:0] prev_result;

    shift_sequencer #(
        .DATA_W  (32),
        .SHAMT_W (5)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: whole-word shift; op only matters when SRA is built.
    function automatic logic [31:0] model(input logic o, input logic [31:0] d, input logic [4:0] s);
        logic signed [31:0] sd;
        sd = d;
        if (SRA_EN && o) return 32'(sd >>> s);
        return d << s;
    endfunction

    // One operation from request to done, checking every cycle in between.
    // With inject set, a second start with other data arrives mid-shift.
    task automatic run_op(input logic o, input logic [31:0] d, input logic [4:0] s, input bit inject);
        int          n;
        logic [31:0] exp;
        n   = (s == 5'd0) ? 1 : int'(s);
        exp = model(o, d, s);
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = s;
        @(negedge clock);
        start   = 1'b0;
        data_in = $urandom;
        shamt   = 5'($urandom);
        op      = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            check_val("busy_shift", {31'd0, busy}, 32'd1);
            check_val("done_shift", {31'd0, done}, 32'd0);
            check_val("result_hold", result, prev_result);
            if (inject && k == 1) begin
                start   = 1'b1;
                data_in = ~d;
                shamt   = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check_val("done_pulse", {31'd0, done}, 32'd1);
        check_val("busy_done", {31'd0, busy}, 32'd0);
        check_val("result", result, exp);
        prev_result = exp;
        @(negedge clock);
        check_val("done_once", {31'd0, done}, 32'd0);
        check_val("busy_idle", {31'd0, busy}, 32'd0);
        check_val("result_kept", result, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        prev_result = 32'd0;
        reset       = 1'b1;
        start       = 1'b0;
        op          = 1'b0;
        data_in     = 32'd0;
        shamt       = 5'd0;
        repeat (2) @(negedge clock);

        // Reset state.
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        shamt = 5'd3;
        @(negedge clock);
        check_val("rst_prio_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check_val("rst_prio_idle", {31'd0, busy}, 32'd0);

        // Directed operations.
        run_op(1'b0, 32'h0000_0001, 5'd4, 1'b0);
        run_op(1'b1, 32'h8000_0000, 5'd31, 1'b0);
        run_op(1'b1, 32'h4000_0000, 5'd2, 1'b0);
        run_op(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0);
        run_op(1'b0, 32'h1234_5678, 5'd5, 1'b1);
        run_op(1'b1, 32'h8765_4321, 5'd5, 1'b1);

        // Reset in the middle of a shamt=8 operation.
        start   = 1'b1;
        op      = 1'b0;
        data_in = 32'h0000_00F3;
        shamt   = 5'd8;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_val("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_result", result, 32'd0);
        reset = 1'b0;
        prev_result = 32'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check_val("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_op(1'b0, 32'h0000_0001, 5'd1, 1'b0);

        // Back-to-back: start held high, shamt=1 -> done every 2 cycles.
        start   = 1'b1;
        op      = 1'b0;
        data_in = 32'h0000_0001;
        shamt   = 5'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check_val("b2b_done", {31'd0, done}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check_val("b2b_busy", {31'd0, busy}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 1) check_val("b2b_result", result, 32'h0000_0002);
        end
        start = 1'b0;
        @(negedge clock);
        check_val("b2b_idle", {31'd0, busy | done}, 32'd0);
        prev_result = 32'h0000_0002;

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), $urandom, 5'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width in bits.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHALL equal clog2(DATA_W).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when state is IDLE or DONE.
REQ-006 op  input  1  0 = shift left logical (SLL), 1 = shift right arithmetic (SRA).
REQ-007 data_in  input  DATA_W  operand; captured on accepted start.
REQ-008 shamt  input  SHAMT_W  shift amount; captured on accepted start.
REQ-009 busy  output  1  high while state is SHIFT.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  DATA_W  shifted operand; held until the next done.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE or DONE with start=1 at an edge: capture data_in, shamt and op; go to SHIFT; count=shamt.
REQ-014 IDLE with start=0 stays in IDLE; DONE with start=0 goes to IDLE.
REQ-015 SHIFT with count>0: work register moves one bit per edge; count decrements; at count==1, next state is DONE.
REQ-016 SHIFT with count==0 (shamt=0): no shift; next state is DONE; result=data_in.
REQ-017 start sampled at edge E0: done SHALL be high for exactly the cycle after edge E0+max(shamt,1).
REQ-018 result SHALL update on the edge entering DONE, never during SHIFT.
REQ-019 SLL SHALL fill bit 0 with 0; bits shifted out of the MSB are discarded.
REQ-020 SRA SHALL fill the MSB with the captured sign bit; bits shifted out of bit 0 are discarded.
REQ-021 start while busy=1 SHALL be ignored; no queuing; captured operands SHALL not change.
REQ-022 start during DONE SHALL be accepted, giving back-to-back operations with one done per operation.
REQ-023 shamt=DATA_W-1 (31) SHALL complete in 31 shift cycles with no counter wrap.

Reset
REQ-024 At reset: state=IDLE, busy=0, done=0, result=0, count=0, work register=0.
REQ-025 Reset SHALL take priority over start at the same edge.
REQ-026 Reset during SHIFT SHALL abort the operation at the next edge with no done pulse.

Configuration
REQ-027 Macro SHIFT_SEQ_SRA_EN defined: op SHALL select SLL or SRA per REQ-006.
REQ-028 Macro SHIFT_SEQ_SRA_EN undefined: op SHALL be ignored, every operation SHALL be SLL, and no right-shift logic SHALL be built.

Structure
REQ-029 Package shift_seq_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), the op codes OP_SLL=0 and OP_SRA=1, and the DATA_W and SHAMT_W defaults.
REQ-030 Sub-module shift_step SHALL implement one combinational one-bit step (left with zero fill, or right with sign fill), used once per cycle on the work register.

Verification
REQ-031 Reset, then start, op=0, data_in=0x0000_0001, shamt=4 at E0 -> busy high for 4 cycles; done after E4; result=0x0000_0010.
REQ-032 SRA enabled: op=1, data_in=0x8000_0000, shamt=31 -> done after E31; result=0xFFFF_FFFF; op=1 with 0x4000_0000, shamt=2 -> 0x1000_0000.
REQ-033 shamt=0, data_in=0xDEAD_BEEF -> done after E1; result=0xDEAD_BEEF; busy high for 1 cycle.
REQ-034 start pulsed again at E2 of a shamt=5 operation with different data -> ignored; single done after E5 with the original result.
REQ-035 Reset asserted at E3 of a shamt=8 operation -> IDLE, busy=0, no done, result=0; a following shamt=1 op with data_in=0x1 (SLL) -> done, result=0x2.
REQ-036 Back-to-back: start held high through DONE with shamt=1, data_in=0x1 (SLL) -> consecutive done pulses every 2 cycles, each result=0x2.
